// File: rtl/wt_wbuf_pkg.sv
// Shared types and default sizing for the write-through dcache store write buffer.
package wt_wbuf_pkg;

  localparam int unsigned WBUF_XLEN  = 32;
  localparam int unsigned WBUF_DEPTH = 8;
  localparam int unsigned WBUF_TID_W = 2;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    PEND = 2'd1,
    SENT = 2'd2,
    DONE = 2'd3
  } wbuf_state_e;

  typedef struct packed {
    logic [WBUF_XLEN-3:0]  waddr;
    logic [31:0]           data;
    logic [3:0]            be;
    logic [WBUF_TID_W-1:0] tid;
    wbuf_state_e           state;
  } wbuf_entry_t;

  // Byte-lane merge: lanes with be set take new_d, the rest keep old_d.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_d,
                                              input logic [31:0] new_d,
                                              input logic [3:0]  be);
    merge_bytes = old_d;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merge_bytes[8*b +: 8] = new_d[8*b +: 8];
    end
  endfunction

endpackage

// File: rtl/wt_wbuf_tid_alloc.sv
// Free-TID bitmap with lowest-free priority encoder for outstanding memory writes.
module wt_wbuf_tid_alloc
  import wt_wbuf_pkg::*;
#(
  parameter int unsigned TID_W = WBUF_TID_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  set_i,
  input  logic [TID_W-1:0]      set_id_i,
  input  logic                  clr_i,
  input  logic [TID_W-1:0]      clr_id_i,
  output logic [TID_W-1:0]      free_id_o,
  output logic                  any_free_o,
  output logic [(1<<TID_W)-1:0] busy_o
);

  localparam int unsigned NTID = 1 << TID_W;

  logic [NTID-1:0] free_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      free_q <= '1;
    end else begin
      if (set_i) free_q[set_id_i] <= 1'b0;
      if (clr_i) free_q[clr_id_i] <= 1'b1;
    end
  end

  // Scan from the top so the lowest free index wins.
  always_comb begin
    free_id_o = '0;
    for (int i = NTID - 1; i >= 0; i--) begin
      if (free_q[i]) free_id_o = TID_W'(i);
    end
  end

  assign any_free_o = |free_q;
  assign busy_o     = ~free_q;

endmodule

// File: rtl/wt_dcache_store_wbuf.sv
// Store write buffer: coalesces same-word stores, issues in order, frees in order on ack.
//
// state | meaning
// FREE  | slot unused
// PEND  | holds a store not yet sent to memory; youngest PEND slot may coalesce
// SENT  | request handed to memory, waiting for ack on its tid
// DONE  | acked, waiting for older slots so it can be freed in order
module wt_dcache_store_wbuf
  import wt_wbuf_pkg::*;
#(
  parameter int unsigned XLEN  = WBUF_XLEN,
  parameter int unsigned DEPTH = WBUF_DEPTH,
  parameter int unsigned TID_W = WBUF_TID_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             st_valid_i,
  output logic             st_ready_o,
  input  logic [XLEN-1:0]  st_addr_i,
  input  logic [31:0]      st_data_i,
  input  logic [3:0]       st_be_i,
  input  logic [XLEN-1:0]  chk_addr_i,
  output logic             chk_hit_o,
  output logic             mem_req_valid_o,
  input  logic             mem_req_ready_i,
  output logic [XLEN-1:0]  mem_addr_o,
  output logic [31:0]      mem_data_o,
  output logic [3:0]       mem_be_o,
  output logic [TID_W-1:0] mem_tid_o,
  input  logic             mem_ack_i,
  input  logic [TID_W-1:0] mem_ack_tid_i,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NTID  = 1 << TID_W;

  wbuf_entry_t ent_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, iss_ptr_q, rd_ptr_q, young_ptr;
  logic [CNT_W-1:0] cnt_q, n_free;
  logic [DEPTH-1:0] done_eff, free_mask;
  logic [XLEN-3:0]  st_waddr, chk_waddr;

  logic             hold_q;
  logic [TID_W-1:0] hold_tid_q;
  logic [TID_W-1:0] free_tid, req_tid;
  logic             any_tid_free;
  logic [NTID-1:0]  tid_busy;

  logic issue_fire, coal_ok, st_fire, do_coal, do_alloc, ack_ok;
  logic unused_addr_lsb;

  assign unused_addr_lsb = ^{st_addr_i[1:0], chk_addr_i[1:0]};

  assign st_waddr  = st_addr_i[XLEN-1:2];
  assign chk_waddr = chk_addr_i[XLEN-1:2];
  assign young_ptr = wr_ptr_q - 1'b1;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);

  wt_wbuf_tid_alloc #(.TID_W(TID_W)) u_tid_alloc (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .set_i      (issue_fire),
    .set_id_i   (req_tid),
    .clr_i      (ack_ok),
    .clr_id_i   (mem_ack_tid_i),
    .free_id_o  (free_tid),
    .any_free_o (any_tid_free),
    .busy_o     (tid_busy)
  );

  // A stalled request keeps its tid even if an ack frees a lower one meanwhile.
  assign req_tid         = hold_q ? hold_tid_q : free_tid;
  assign mem_req_valid_o = (ent_q[iss_ptr_q].state == PEND) && any_tid_free;
  assign mem_addr_o      = {ent_q[iss_ptr_q].waddr, 2'b00};
  assign mem_data_o      = ent_q[iss_ptr_q].data;
  assign mem_be_o        = ent_q[iss_ptr_q].be;
  assign mem_tid_o       = req_tid;
  assign issue_fire      = mem_req_valid_o && mem_req_ready_i;

  assign coal_ok = (ent_q[young_ptr].state == PEND) &&
                   (ent_q[young_ptr].waddr == st_waddr) &&
                   !(issue_fire && (iss_ptr_q == young_ptr));

  assign st_ready_o = !full_o || coal_ok;
  assign st_fire    = st_valid_i && st_ready_o;
  assign do_coal    = st_fire && coal_ok;
  assign do_alloc   = st_fire && !coal_ok;
  assign ack_ok     = mem_ack_i && tid_busy[mem_ack_tid_i];

  always_comb begin
    done_eff = '0;
    for (int i = 0; i < DEPTH; i++) begin
      done_eff[i] = (ent_q[i].state == DONE) ||
                    ((ent_q[i].state == SENT) && ack_ok && (ent_q[i].tid == mem_ack_tid_i));
    end
  end

  // Free the unbroken run of completed entries starting at the oldest.
  always_comb begin
    logic             run;
    logic [PTR_W-1:0] idx;
    free_mask = '0;
    n_free    = '0;
    run       = 1'b1;
    idx       = rd_ptr_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PTR_W'(k);
      if (run && done_eff[idx]) begin
        free_mask[idx] = 1'b1;
        n_free         = n_free + 1'b1;
      end else begin
        run = 1'b0;
      end
    end
  end

  always_comb begin
    chk_hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((ent_q[i].state != FREE) && (ent_q[i].waddr == chk_waddr)) chk_hit_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (free_mask[i]) begin
          ent_q[i].state <= FREE;
        end else if (done_eff[i] && (ent_q[i].state == SENT)) begin
          ent_q[i].state <= DONE;
        end
        if (issue_fire && (iss_ptr_q == PTR_W'(i))) begin
          ent_q[i].state <= SENT;
          ent_q[i].tid   <= req_tid;
        end
        if (do_alloc && (wr_ptr_q == PTR_W'(i))) begin
          ent_q[i] <= '{waddr: st_waddr, data: st_data_i, be: st_be_i, tid: '0, state: PEND};
        end
        if (do_coal && (young_ptr == PTR_W'(i))) begin
          ent_q[i].be   <= ent_q[i].be | st_be_i;
          ent_q[i].data <= merge_bytes(ent_q[i].data, st_data_i, st_be_i);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      iss_ptr_q  <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      hold_q     <= 1'b0;
      hold_tid_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_q + PTR_W'(do_alloc);
      iss_ptr_q <= iss_ptr_q + PTR_W'(issue_fire);
      rd_ptr_q  <= rd_ptr_q + n_free[PTR_W-1:0];
      cnt_q     <= cnt_q + CNT_W'(do_alloc) - n_free;
      if (issue_fire) begin
        hold_q <= 1'b0;
      end else if (mem_req_valid_o) begin
        hold_q     <= 1'b1;
        hold_tid_q <= req_tid;
      end
    end
  end

  ack_tid_busy_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_ack_i |-> tid_busy[mem_ack_tid_i]);

endmodule
